memory_cmd_sequencer: RTL and testbench

//  Command front-end sitting directly upstream of memory_m: accepts READ/WRITE/FILL

---
 rtl/memory_cmd_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_memory_cmd_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_cmd_sequencer.sv
// Command front-end for memory_m: buffers READ/WRITE/FILL commands in a FIFO,
// drives registered memory strobes/address/data and returns read data over valid/ready.
module memory_cmd_sequencer #(
    parameter int DWIDTH    = 8,
    parameter int AWIDTH    = 5,
    parameter int CMD_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_data,
    output logic [AWIDTH-1:0] rsp_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);

    localparam int PW = $clog2(CMD_DEPTH);
    localparam int EW = 2 + AWIDTH + DWIDTH;
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [PW:0]     PTR_ONE = 1;
    localparam logic [AWIDTH:0] CNT_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RSP,
        S_FILL
    } state_t;

    state_t              state_q, state_d;
    logic [EW-1:0]       fifo_mem_q [CMD_DEPTH];
    logic [PW:0]         wr_ptr_q, wr_ptr_d;
    logic [PW:0]         rd_ptr_q, rd_ptr_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [AWIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [AWIDTH-1:0]   rsp_addr_q, rsp_addr_d;
    logic                err_q, err_d;
    logic [AWIDTH:0]     fill_cnt_q, fill_cnt_d;
    logic [DWIDTH-1:0]   fill_data_q, fill_data_d;

    logic                fifo_empty, fifo_full, push, pop;
    logic [EW-1:0]       head;
    logic [1:0]          head_op;
    logic [AWIDTH-1:0]   head_addr;
    logic [DWIDTH-1:0]   head_wdata;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign push       = cmd_valid && !fifo_full;
    assign head       = fifo_mem_q[rd_ptr_q[PW-1:0]];
    assign head_op    = head[EW-1 -: 2];
    assign head_addr  = head[DWIDTH +: AWIDTH];
    assign head_wdata = head[DWIDTH-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[PW-1:0]] <= {cmd_op, cmd_addr, cmd_wdata};
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_addr_d  = rsp_addr_q;
        err_d       = err_q;
        fill_cnt_d  = fill_cnt_q;
        fill_data_d = fill_data_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    case (head_op)
                        OP_WRITE: begin
                            mem_write_d = 1'b1;
                            mem_addr_d  = head_addr;
                            mem_wdata_d = head_wdata;
                        end
                        OP_READ: begin
                            mem_read_d = 1'b1;
                            mem_addr_d = head_addr;
                            state_d    = S_RD_ISSUE;
                        end
                        OP_FILL: begin
                            fill_cnt_d  = '0;
                            fill_data_d = head_wdata;
                            state_d     = S_FILL;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_RD_ISSUE: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                // mem_addr still holds the read address: no strobe has fired since.
                rsp_valid_d = 1'b1;
                rsp_data_d  = mem_rdata;
                rsp_addr_d  = mem_addr_q;
                state_d     = S_RSP;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_FILL: begin
                mem_write_d = 1'b1;
                mem_addr_d  = fill_cnt_q[AWIDTH-1:0];
                mem_wdata_d = fill_data_q;
                fill_cnt_d  = fill_cnt_q + CNT_ONE;
                if (fill_cnt_d[AWIDTH]) begin
                    fill_cnt_d = '0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
            err_q       <= 1'b0;
            fill_cnt_q  <= '0;
            fill_data_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_addr_q  <= rsp_addr_d;
            err_q       <= err_d;
            fill_cnt_q  <= fill_cnt_d;
            fill_data_q <= fill_data_d;
        end
    end

    assign cmd_ready = !fifo_full;
    assign busy      = (state_q != S_IDLE) || !fifo_empty;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_memory_cmd_sequencer.sv
// Directed bench for memory_cmd_sequencer with a behavioural memory_m model
// (write at the strobe edge, read data registered one edge after the strobe).
module tb_memory_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [4:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [4:0] rsp_addr;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       err;

    logic [7:0] mem_model [32];
    int checks = 0;
    int failures = 0;

    memory_cmd_sequencer #(.DWIDTH(8), .AWIDTH(5), .CMD_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) mem_model[mem_addr] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem_model[mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_mem_write"}, mem_write, 0);
        check({tag, "_mem_read"},  mem_read, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
    endtask

    // With rsp_ready held high, the response is consumed at the edge after it is seen.
    task automatic wait_rsp(input string tag, input logic [7:0] exp_d, input logic [4:0] exp_a);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_data"}, rsp_data, exp_d);
        check({tag, "_addr"}, rsp_addr, exp_a);
        step();
    endtask

    initial begin
        int n;
        int wr_cnt;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_addr = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        step();
        step();
        check_idle("reset");
        check("reset_err", err, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_rsp_data", rsp_data, 0);
        rst = 1'b0;
        step();

        // Test 1: reset in the middle of a FILL
        send(2'b10, 5'd0, 8'h77);
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (!(mem_write && mem_addr == 5'd7) && n < 50) begin
            step();
            n++;
        end
        check("t1_fill_at_7", mem_addr, 7);
        rst = 1'b1;
        step();
        step();
        check_idle("t1_rst");
        rst = 1'b0;
        step();
        check_idle("t1_after");

        // Test 2: WRITE then READ of the same address
        send(2'b01, 5'd5, 8'hA5);
        step();
        send(2'b00, 5'd5, 8'h00);
        step();
        cmd_valid = 1'b0;
        check("t2_wr_strobe", mem_write, 1);
        check("t2_wr_addr", mem_addr, 5);
        check("t2_wr_data", mem_wdata, 8'hA5);
        check("t2_wr_no_read", mem_read, 0);
        step();
        check("t2_wr_one_cycle", mem_write, 0);
        check("t2_rd_strobe", mem_read, 1);
        check("t2_rd_addr", mem_addr, 5);
        check("t2_rd_wdata_held", mem_wdata, 8'hA5);
        step();
        check("t2_rd_one_cycle", mem_read, 0);
        check("t2_rsp_not_yet", rsp_valid, 0);
        step();
        check("t2_rsp_valid", rsp_valid, 1);
        check("t2_rsp_data", rsp_data, 8'hA5);
        check("t2_rsp_addr", rsp_addr, 5);
        rsp_ready = 1'b1;
        step();
        check("t2_rsp_done", rsp_valid, 0);
        check("t2_idle_busy", busy, 0);

        // Test 3: back-to-back writes
        send(2'b01, 5'd1, 8'h11);
        step();
        send(2'b01, 5'd2, 8'h22);
        step();
        check("t3_w1_strobe", mem_write, 1);
        check("t3_w1_addr", mem_addr, 1);
        send(2'b01, 5'd3, 8'h33);
        step();
        cmd_valid = 1'b0;
        check("t3_w2_strobe", mem_write, 1);
        check("t3_w2_addr", mem_addr, 2);
        step();
        check("t3_w3_strobe", mem_write, 1);
        check("t3_w3_addr", mem_addr, 3);
        check("t3_w3_data", mem_wdata, 8'h33);
        step();
        check("t3_end_strobe", mem_write, 0);
        check("t3_addr_held", mem_addr, 3);
        check("t3_data_held", mem_wdata, 8'h33);

        // Test 4: stalled responses with a full command FIFO
        rsp_ready = 1'b0;
        send(2'b00, 5'd5, 8'h00);
        step();
        check("t4_ready1", cmd_ready, 1);
        send(2'b00, 5'd3, 8'h00);
        step();
        send(2'b00, 5'd2, 8'h00);
        step();
        send(2'b00, 5'd1, 8'h00);
        step();
        check("t4_ready4", cmd_ready, 1);
        send(2'b00, 5'd5, 8'h00);
        step();
        cmd_valid = 1'b0;
        check("t4_full", cmd_ready, 0);
        check("t4_first_rsp", rsp_valid, 1);
        check("t4_first_data", rsp_data, 8'hA5);
        step();
        step();
        check("t4_stall_valid", rsp_valid, 1);
        check("t4_stall_data", rsp_data, 8'hA5);
        check("t4_stall_addr", rsp_addr, 5);
        check("t4_stall_full", cmd_ready, 0);
        rsp_ready = 1'b1;
        wait_rsp("t4_r0", 8'hA5, 5'd5);
        wait_rsp("t4_r1", 8'h33, 5'd3);
        wait_rsp("t4_r2", 8'h22, 5'd2);
        wait_rsp("t4_r3", 8'h11, 5'd1);
        wait_rsp("t4_r4", 8'hA5, 5'd5);
        step();
        check("t4_drained_busy", busy, 0);
        check("t4_drained_ready", cmd_ready, 1);

        // Test 5: FILL the whole array, then read back the last word
        send(2'b10, 5'd9, 8'h3C);
        step();
        cmd_valid = 1'b0;
        wr_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (mem_write) begin
                check("t5_fill_addr", mem_addr, wr_cnt);
                check("t5_fill_data", mem_wdata, 8'h3C);
                wr_cnt++;
            end
            step();
        end
        check("t5_fill_count", wr_cnt, 32);
        check("t5_idle", busy, 0);
        send(2'b00, 5'd31, 8'h00);
        step();
        cmd_valid = 1'b0;
        wait_rsp("t5_rd31", 8'h3C, 5'd31);
        send(2'b00, 5'd0, 8'h00);
        step();
        cmd_valid = 1'b0;
        wait_rsp("t5_rd0", 8'h3C, 5'd0);

        // Test 6: reserved op sets a sticky error
        check("t6_err_before", err, 0);
        send(2'b11, 5'd4, 8'hEE);
        step();
        cmd_valid = 1'b0;
        check("t6_no_wr_a", mem_write, 0);
        step();
        check("t6_no_wr_b", mem_write, 0);
        check("t6_no_rd_b", mem_read, 0);
        check("t6_err_set", err, 1);
        send(2'b01, 5'd4, 8'h44);
        step();
        cmd_valid = 1'b0;
        step();
        check("t6_next_write", mem_write, 1);
        check("t6_next_addr", mem_addr, 4);
        check("t6_err_sticky", err, 1);
        step();
        step();
        check("t6_err_still", err, 1);
        rst = 1'b1;
        step();
        check("t6_err_cleared", err, 0);
        rst = 1'b0;
        step();
        check("t6_err_stays_clear", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
